seq_booth_mult: RTL and testbench

- Parametrised sequential multiplier; the next generation of the team's 6-bit combinational unsigned array multiplier.
- Radix-2 Booth datapath, one iteration per clock.
- Runtime-selectable signed or unsigned operands.
- start/busy/done handshake, so it can sit as a multi-cycle functional unit beside the ALU in the lab datapath.
- Trades array-multiplier area for WIDTH+1 cycles of latency.

---
 rtl/mult_defs.sv | 31 +++
 rtl/booth_step.sv | 31 +++
 rtl/seq_booth_mult.sv | 110 +++++++++++
 tb/tb_seq_booth_mult.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_defs.sv
// Shared encodings for the sequential Booth multiplier:
// FSM states and the per-iteration Booth recode operation.
package mult_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } booth_op_e;

  function automatic booth_op_e booth_op(
    input logic q0,
    input logic q_1
  );
    booth_op_e op;
    op = OP_NOP;
    unique case (1'b1)
      (!q0 && q_1): op = OP_ADD;
      (q0 && !q_1): op = OP_SUB;
      default:      op = OP_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/sub M into A, then
// arithmetic right shift of {A,Q,q_1}.
module booth_step
  import mult_defs::*;
#(
  parameter int W = 6
) (
  input  logic [W:0] a_i,
  input  logic [W:0] m_i,
  input  logic [W:0] q_i,
  input  logic       q_1_i,
  output logic [W:0] a_o,
  output logic [W:0] q_o,
  output logic       q_1_o
);

  logic [W:0] sum;

  always_comb begin
    sum = a_i;
    unique case (booth_op(q_i[0], q_1_i))
      OP_ADD:  sum = a_i + m_i;
      OP_SUB:  sum = a_i - m_i;
      default: sum = a_i;
    endcase
    a_o   = {sum[W], sum[W:1]};
    q_o   = {sum[0], q_i[W:1]};
    q_1_o = q_i[0];
  end

endmodule

// File: rtl/seq_booth_mult.sv
// Sequential radix-2 Booth multiplier, signed or unsigned,
// one iteration per clock with a start/busy/done handshake.
module seq_booth_mult
  import mult_defs::*;
#(
  parameter int WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] ITERS = CW'(WIDTH + 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH:0]     mq_q, mq_d;
  logic [WIDTH:0]     m_q, m_d;
  logic               q1_q, q1_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [WIDTH:0]     acc_n, mq_n;
  logic               q1_n;

  // One extra bit lets unsigned operands ride the signed datapath.
  function automatic logic [WIDTH:0] ext(
    input logic [WIDTH-1:0] x,
    input logic             s
  );
    return {s & x[WIDTH-1], x};
  endfunction

  booth_step #(.W(WIDTH)) u_step (
    .a_i   (acc_q),
    .m_i   (m_q),
    .q_i   (mq_q),
    .q_1_i (q1_q),
    .a_o   (acc_n),
    .q_o   (mq_n),
    .q_1_o (q1_n)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    m_d     = m_q;
    q1_d    = q1_q;
    prod_d  = prod_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = ITERS;
          acc_d   = '0;
          mq_d    = ext(b, is_signed);
          m_d     = ext(a, is_signed);
          q1_d    = 1'b0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = acc_n;
        mq_d  = mq_n;
        q1_d  = q1_n;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          prod_d  = {acc_n[WIDTH-2:0], mq_n};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      m_q     <= '0;
      q1_q    <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      m_q     <= m_d;
      q1_q    <= q1_d;
      prod_q  <= prod_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = prod_q;

endmodule

// File: tb/tb_seq_booth_mult.sv
// Scoreboard bench for seq_booth_mult: directed and random
// operands against an integer-arithmetic reference.
module tb_seq_booth_mult;

  localparam int W = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           is_signed = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy, done;
  logic [2*W-1:0] product;

  seq_booth_mult #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] exp;
    int             cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   hold = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2*W-1:0] model(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic         s
  );
    longint vx, vy, p;
    vx = longint'(x);
    vy = longint'(y);
    if (s && x[W-1]) vx -= (longint'(1) << W);
    if (s && y[W-1]) vy -= (longint'(1) << W);
    p = vx * vy;
    return p[2*W-1:0];
  endfunction

  // Monitor: pops the scoreboard on each done pulse.
  logic           prev_done = 1'b0;
  logic [2*W-1:0] prev_prod = '0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_done = 1'b0;
      prev_prod = product;
    end else begin
      if (busy) begin
        total++;
        if (product !== prev_prod) begin
          bad++;
          $display("FAIL prod_stable: got %h want %h", product, prev_prod);
        end
      end
      if (done) begin
        total++;
        if (prev_done) begin
          bad++;
          $display("FAIL done_width: done high %0d cycles, want 1", 2);
        end
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: product %h with empty queue",
                   product);
        end else begin
          e = sb.pop_front();
          total++;
          if (product !== e.exp) begin
            bad++;
            $display("FAIL product: got %h want %h", product, e.exp);
          end
          total++;
          if (cyc - e.cyc != W + 1) begin
            bad++;
            $display("FAIL latency: got %0d want %0d", cyc - e.cyc, W + 1);
          end
        end
      end
      prev_done = done;
      prev_prod = product;
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(
    input  logic [W-1:0]   ia,
    input  logic [W-1:0]   ib,
    input  logic           is,
    input  logic [2*W-1:0] exp,
    output int             acc_cyc
  );
    int n = 0;
    acc_cyc = -1;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL busy_timeout: busy=%b after %0d cycles, want 0", busy, n);
      return;
    end
    a = ia;
    b = ib;
    is_signed = is;
    start = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    sb.push_back('{exp, cyc});
    @(negedge clk);
    if (!hold) start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    is_signed = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d pending, want 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic           s;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t dir[$];

  initial begin
    int t0, t1, t2;
    logic [W-1:0] rx, ry;
    logic rs;

    dir.push_back('{6'd43, 6'd55, 1'b0, 12'h93D});
    dir.push_back('{6'b101011, 6'd11, 1'b1, 12'hF19});
    dir.push_back('{6'b101011, 6'd11, 1'b0, 12'd473});
    dir.push_back('{6'd63, 6'd63, 1'b0, 12'hF81});
    dir.push_back('{6'b100000, 6'b100000, 1'b1, 12'h400});
    dir.push_back('{6'b100000, 6'd31, 1'b1, 12'hC20});
    dir.push_back('{6'd0, 6'd45, 1'b0, 12'd0});
    dir.push_back('{6'd0, 6'd45, 1'b1, 12'd0});

    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      bad++;
      $display("FAIL reset_state: busy=%b done=%b product=%h want 0 0 0",
               busy, done, product);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (dir[i]) begin
      issue(dir[i].x, dir[i].y, dir[i].s, dir[i].exp, t0);
      drain();
    end

    hold = 1;
    issue(6'd5, 6'd7, 1'b0, 12'd35, t0);
    issue(6'b111111, 6'd3, 1'b1, 12'hFFD, t1);
    issue(6'd2, 6'd3, 1'b0, 12'd6, t2);
    hold = 0;
    start = 1'b0;
    total++;
    if (t1 - t0 != W + 2 || t2 - t1 != W + 2) begin
      bad++;
      $display("FAIL back_to_back: spacing %0d %0d want %0d",
               t1 - t0, t2 - t1, W + 2);
    end
    drain();

    issue(6'd24, 6'd25, 1'b0, 12'd600, t0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      bad++;
      $display("FAIL mid_reset: busy=%b done=%b product=%h want 0 0 0",
               busy, done, product);
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    issue(6'd24, 6'd25, 1'b0, 12'd600, t0);
    drain();

    for (int i = 0; i < 500; i++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      rs = 1'($urandom);
      issue(rx, ry, rs, model(rx, ry, rs), t0);
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 12)) @(negedge clk);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
